// File: rtl/outport_arb_pkg.sv
// Shared router definitions: port count, port-index width and flit-type encodings.
// Also holds the cyclic next-port helper used when the round-robin pointer advances.
package outport_arb_pkg;

  localparam int NPORT_C = 5;
  localparam int PIDX_W  = 3;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_t;

  function automatic logic [PIDX_W-1:0] next_port(input logic [PIDX_W-1:0] p);
    return (p == PIDX_W'(NPORT_C - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first requester at or after rr_ptr, wrapping past the last port.
// Purely combinational; no state and no flow control.
module rr_pick
  import outport_arb_pkg::*;
(
  input  logic [NPORT_C-1:0] req,
  input  logic [PIDX_W-1:0]  rr_ptr,
  output logic [NPORT_C-1:0] win,
  output logic [PIDX_W-1:0]  win_idx
);

  logic              found;
  logic [PIDX_W:0]   sum;
  logic [PIDX_W-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NPORT_C; k++) begin
      sum = {1'b0, rr_ptr} + (PIDX_W+1)'(k);
      idx = (sum >= (PIDX_W+1)'(NPORT_C)) ? PIDX_W'(sum - (PIDX_W+1)'(NPORT_C))
                                          : PIDX_W'(sum);
      if (!found && req[idx]) begin
        found        = 1'b1;
        win[idx]     = 1'b1;
        win_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/outport_arb.sv
// Output-channel arbiter: round-robin grant, held until the owner's tail or abort.
// Latency: grant registered one cycle after req; release takes one idle cycle.
// Backpressure: none internally; owner keeps the channel while it stalls with req high.
module outport_arb
  import outport_arb_pkg::*;
#(
  parameter int PCHID = 0,
  parameter int NPORT = NPORT_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORT-1:0]  req,
  input  logic [NPORT-1:0]  send,
  input  logic [NPORT-1:0]  tail,
  output logic [NPORT-1:0]  grt,
  output logic [PIDX_W-1:0] sel,
  output logic              olck
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [PIDX_W-1:0] rr_ptr;
  logic [NPORT-1:0]  win;
  logic [PIDX_W-1:0] win_idx;
  logic              release_now;
  logic              unused_pchid;

  assign unused_pchid = (PCHID != 0);

  rr_pick u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // Only the owner's strobes matter; sel indexes the owner while locked.
  assign release_now = (send[sel] && tail[sel]) || (!req[sel] && !send[sel]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grt    <= '0;
      sel    <= '0;
      olck   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grt   <= win;
            sel   <= win_idx;
            olck  <= 1'b1;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (release_now) begin
            grt    <= '0;
            sel    <= '0;
            olck   <= 1'b0;
            rr_ptr <= next_port(sel);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outport_arb.sv
// Directed bench for outport_arb: expected outputs are queued with each stimulus step
// and popped after the following rising edge.
module tb_outport_arb;

  typedef struct packed {
    logic [4:0] grt;
    logic [2:0] sel;
    logic       olck;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req, send, tail;
  logic [4:0] grt;
  logic [2:0] sel;
  logic       olck;

  int vectors     = 0;
  int miscompares = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  outport_arb #(.PCHID(0), .NPORT(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .send (send),
    .tail (tail),
    .grt  (grt),
    .sel  (sel),
    .olck (olck)
  );

  always #5 clk = ~clk;

  function automatic obs_t own(input int p);
    obs_t o;
    o.grt  = 5'b00001 << p;
    o.sel  = 3'(p);
    o.olck = 1'b1;
    return o;
  endfunction

  localparam obs_t IDLE_O = '0;

  // Drive one cycle of inputs, queue the expected registered outputs, then check after the edge.
  task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] sd,
                      input logic [4:0] tl, input obs_t e, input string tag);
    obs_t  want;
    obs_t  got;
    string t;
    rst  = r;
    req  = rq;
    send = sd;
    tail = tl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    got  = '{grt: grt, sel: sel, olck: olck};
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got grt=%b sel=%0d olck=%b, expected grt=%b sel=%0d olck=%b",
             t, got.grt, got.sel, got.olck, want.grt, want.sel, want.olck);
    end
    vectors++;
    assert ($countones(grt) <= 1) else begin
      miscompares++;
      $error("FAIL %s_onehot: got grt=%b, expected at most one bit set", t, grt);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; send = '0; tail = '0;

    step(1, 5'b00000, 0, 0, IDLE_O, "reset");
    step(0, 5'b00000, 0, 0, IDLE_O, "idle_noreq");

    // Single request, tail release, pointer moves to 3.
    step(0, 5'b00100, 0, 0, own(2), "grant_p2");
    step(0, 5'b00100, 5'b00100, 5'b00100, IDLE_O, "release_p2");
    step(0, 5'b11111, 0, 0, own(3), "ptr_after_p2");
    step(0, 5'b11111, 5'b01000, 5'b01000, IDLE_O, "release_p3");

    // Full contention from pointer 0, single HEADTAIL each.
    step(1, 5'b00000, 0, 0, IDLE_O, "reset2");
    for (int i = 0; i < 6; i++) begin
      step(0, 5'b11111, 0, 0, own(i % 5), $sformatf("rr_grant_%0d", i));
      step(0, 5'b11111, 5'b00001 << (i % 5), 5'b00001 << (i % 5), IDLE_O,
           $sformatf("rr_gap_%0d", i));
    end

    // Port 1 multi-flit packet with ports 0 and 3 waiting.
    step(0, 5'b01011, 0, 0, own(1), "p1_grant");
    step(0, 5'b01011, 5'b00010, 5'b00000, own(1), "p1_body1");
    step(0, 5'b01011, 5'b00010, 5'b00000, own(1), "p1_body2");
    step(0, 5'b01011, 5'b00010, 5'b00010, IDLE_O, "p1_tail");
    step(0, 5'b01001, 0, 0, own(3), "after_p1_p3");
    step(0, 5'b01001, 5'b01000, 5'b01000, IDLE_O, "release_p3b");

    // Pointer wrap from port 4.
    step(0, 5'b10001, 0, 0, own(4), "p4_grant");
    step(0, 5'b10001, 5'b10000, 5'b10000, IDLE_O, "p4_tail");
    step(0, 5'b10001, 0, 0, own(0), "wrap_p0");
    step(0, 5'b00001, 5'b00001, 5'b00001, IDLE_O, "release_p0");

    // Abort release and non-owner strobes.
    step(0, 5'b00100, 0, 0, own(2), "p2_grant");
    step(0, 5'b00101, 5'b00001, 5'b00001, own(2), "nonowner_tail");
    step(0, 5'b00001, 0, 0, IDLE_O, "p2_abort");
    step(0, 5'b11111, 0, 0, own(3), "ptr_after_abort");

    // Reset mid-packet, then search restarts at port 0.
    step(1, 5'b01000, 0, 0, IDLE_O, "rst_midpkt");
    step(0, 5'b01000, 0, 0, own(3), "post_rst_p3");
    step(1, 5'b00000, 0, 0, IDLE_O, "reset3");
    step(0, 5'b11111, 0, 0, own(0), "post_rst_ptr0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
